axis_burst_sequencer: RTL and testbench

- Controller placed between a free-running AXI-stream source (e.g. a sample counter) and a downstream consumer.
- Gates the source into a programmed number of bursts of fixed length, separated by idle gaps. Marks the last beat of each burst with m_tlast.
- Back-pressures the source (s_tready=0) outside bursts, so a counter source holds its value across gaps and idle time.
- Zero-latency combinational pass-through of data; only the control path is sequential.

---
 rtl/axis_burst_sequencer_pkg.sv | 13 +
 rtl/axis_beat_counter.sv | 40 ++++
 rtl/axis_burst_sequencer.sv | 151 +++++++++++++++
 tb/tb_axis_burst_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_burst_sequencer_pkg.sv
// Shared definitions for the AXI-stream burst sequencer.
//   state_t : control FSM encoding (IDLE, BURST, GAP) on a 2-bit vector.
package axis_burst_sequencer_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/axis_beat_counter.sv
// Clearable up-counter with terminal-count compare against a programmed limit.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset
//   clear    : force count to zero (wins over enable)
//   enable   : advance the count; at terminal the count wraps back to zero
//   limit    : number of counts per cycle of the counter (must be nonzero)
//   terminal : high while count == limit-1
module axis_beat_counter
  import axis_burst_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  // Compare against limit-1 so an all-ones limit never needs a wider counter.
  assign terminal = (count == limit - ONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/axis_burst_sequencer.sv
// Gates a free-running AXI-stream source into burst_count bursts of
// burst_length beats separated by gap_length idle cycles.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, abort        : one-cycle run request / synchronous stop
//   burst_length        : beats per burst
//   gap_length          : idle cycles between bursts
//   burst_count         : number of bursts
//   busy, done          : run in progress / one-cycle completion pulse
//   s_tdata/tvalid/tready : upstream stream (back-pressured outside bursts)
//   m_tdata/tvalid/tready/tlast : downstream stream, tlast on last beat of a burst
module axis_burst_sequencer
  import axis_burst_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  (* X_INTERFACE_PARAMETER = "POLARITY ACTIVE_HIGH" *)
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LEN_WIDTH-1:0]   burst_length,
  input  logic [LEN_WIDTH-1:0]   gap_length,
  input  logic [COUNT_WIDTH-1:0] burst_count,
  output logic                   busy,
  output logic                   done,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                 state, state_next;
  logic [LEN_WIDTH-1:0]   cfg_len, cfg_gap;
  logic [COUNT_WIDTH-1:0] cfg_count, burst_cnt;
  logic                   done_q, done_next;
  logic                   cfg_load, burst_inc, burst_clear;
  logic                   in_burst, handshake, final_burst;
  logic                   beat_last, gap_last;

  // Data path is a pure wire; only the control path is registered.
  assign m_tdata   = s_tdata;
  assign in_burst  = (state == ST_BURST);
  assign m_tvalid  = in_burst & s_tvalid;
  assign s_tready  = in_burst & m_tready;
  assign handshake = s_tvalid & s_tready;
  assign m_tlast   = m_tvalid & beat_last;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

  assign final_burst = (burst_cnt == cfg_count - COUNT_ONE);

  // Beat position within the current burst; only handshakes advance it, so
  // stalls hold it and tlast stays stable.
  axis_beat_counter #(.WIDTH(LEN_WIDTH)) u_beat_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (abort | ~in_burst),
    .enable   (handshake),
    .limit    (cfg_len),
    .terminal (beat_last)
  );

  // Idle cycles spent in GAP; held at zero elsewhere so each gap starts fresh.
  axis_beat_counter #(.WIDTH(LEN_WIDTH)) u_gap_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (abort | (state != ST_GAP)),
    .enable   (1'b1),
    .limit    (cfg_gap),
    .terminal (gap_last)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    done_next   = 1'b0;
    cfg_load    = 1'b0;
    burst_inc   = 1'b0;
    burst_clear = 1'b0;

    if (abort) begin
      state_next  = ST_IDLE;
      burst_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_load    = 1'b1;
            burst_clear = 1'b1;
            // An empty run completes immediately without moving data.
            if (burst_length == '0 || burst_count == '0) begin
              done_next = 1'b1;
            end else begin
              state_next = ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (handshake && beat_last) begin
            if (final_burst) begin
              state_next  = ST_IDLE;
              done_next   = 1'b1;
              burst_clear = 1'b1;
            end else begin
              burst_inc = 1'b1;
              // Zero gap keeps bursts back-to-back.
              if (cfg_gap != '0) state_next = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_last) state_next = ST_BURST;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      done_q    <= 1'b0;
      cfg_len   <= '0;
      cfg_gap   <= '0;
      cfg_count <= '0;
      burst_cnt <= '0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      if (cfg_load) begin
        cfg_len   <= burst_length;
        cfg_gap   <= gap_length;
        cfg_count <= burst_count;
      end
      if (burst_clear) begin
        burst_cnt <= '0;
      end else if (burst_inc) begin
        burst_cnt <= burst_cnt + COUNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_axis_burst_sequencer.sv
// Self-checking bench for axis_burst_sequencer. A counter source feeds the
// DUT; each run pushes the beats it should deliver into a scoreboard queue
// and a negedge monitor pops and compares on every downstream handshake.
module tb_axis_burst_sequencer;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] burst_length = '0;
  logic [15:0] gap_length = '0;
  logic [15:0] burst_count = '0;
  logic        busy, done;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  logic [15:0] src_cnt = '0;
  bit          rand_mode = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_count = 0;
  beat_t       exp_q[$];

  axis_burst_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .burst_length (burst_length),
    .gap_length   (gap_length),
    .burst_count  (burst_count),
    .busy         (busy),
    .done         (done),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast)
  );

  always #5 clock = ~clock;

  // Free-running counter source: advances only when a beat is accepted.
  assign s_tdata = src_cnt;
  always @(posedge clock) if (s_tvalid && s_tready) src_cnt <= src_cnt + 16'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: a run of n beats from the current source value, with
  // tlast on every len-th beat.
  task automatic push_beats(input int len, input int n);
    int base;
    base = int'(src_cnt);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = 16'(base + i);
      b.last = ((i % len) == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic issue_start(input int len, input int gap, input int cnt);
    step();
    burst_length = 16'(len);
    gap_length   = 16'(gap);
    burst_count  = 16'(cnt);
    start        = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full-rate run: downstream always ready and source always valid, so the
  // valid pattern is periodic with period len+gap.
  task automatic run_expect(input int len, input int gap, input int cnt, input bit poke);
    int total;
    int period;
    push_beats(len, cnt * len);
    total  = cnt * len + (cnt - 1) * gap;
    period = len + gap;
    issue_start(len, gap, cnt);
    for (int k = 0; k <= total + 1; k++) begin
      @(negedge clock);
      if (k < total) begin
        check("busy_in_run", 32'(busy), 32'd1);
        check("done_in_run", 32'(done), 32'd0);
        check("valid_pattern", 32'(m_tvalid), 32'((k % period) < len));
        if ((k % period) >= len) check("tready_in_gap", 32'(s_tready), 32'd0);
      end else if (k == total) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_after_run", 32'(busy), 32'd0);
      end else begin
        check("done_single", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
      end
      if (poke && k == 1) begin
        step();
        start = 1'b1;
        burst_length = 16'd7;
        gap_length   = 16'd5;
        burst_count  = 16'd9;
      end
      if (poke && k == 2) begin
        step();
        start = 1'b0;
      end
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Downstream ready / upstream valid generator.
  initial begin
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rand_mode) begin
        m_tready = ($urandom_range(0, 3) != 0);
        s_tvalid = ($urandom_range(0, 4) != 0);
      end else begin
        m_tready = 1'b1;
        s_tvalid = 1'b1;
      end
    end
  end

  // Monitor: compares every presented beat against the scoreboard head.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("tdata_passthru", 32'(m_tdata), 32'(s_tdata));
        if (m_tvalid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat", 32'(m_tdata));
          end else begin
            check("beat_data", 32'(m_tdata), 32'(exp_q[0].data));
            check("beat_last", 32'(m_tlast), 32'(exp_q[0].last));
            if (m_tready) begin
              void'(exp_q.pop_front());
              hs_count++;
            end
          end
        end else begin
          check("tlast_without_valid", 32'(m_tlast), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done_seen;
    void'($urandom(32'd1234));

    // Reset state.
    repeat (3) step();
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // Three bursts of four with two-cycle gaps.
    run_expect(4, 2, 3, 1'b0);

    // Back-to-back bursts, with a start poked mid-run that must be ignored.
    run_expect(3, 0, 2, 1'b1);

    // Random stalls on both sides.
    hs_count = 0;
    push_beats(5, 10);
    rand_mode = 1'b1;
    issue_start(5, 3, 2);
    done_seen = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      @(negedge clock);
      if (done) done_seen = 1'b1;
    end
    check("rand_done_seen", 32'(done_seen), 32'd1);
    check("rand_transfers", 32'(hs_count), 32'd10);
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    rand_mode = 1'b0;
    repeat (2) step();

    // Empty runs: zero length, then zero count.
    for (int z = 0; z < 2; z++) begin
      issue_start((z == 0) ? 0 : 4, 2, (z == 0) ? 3 : 0);
      @(negedge clock);
      check("empty_done", 32'(done), 32'd1);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_s_tready", 32'(s_tready), 32'd0);
      @(negedge clock);
      check("empty_done_end", 32'(done), 32'd0);
      check("empty_busy_end", 32'(busy), 32'd0);
      check("empty_s_tready_end", 32'(s_tready), 32'd0);
    end

    // Abort on the second beat of burst two: six beats delivered, no done.
    push_beats(4, 6);
    issue_start(4, 2, 3);
    repeat (7) @(negedge clock);
    step();
    abort = 1'b1;
    @(negedge clock);
    check("abort_cycle_busy", 32'(busy), 32'd1);
    check("abort_cycle_valid", 32'(m_tvalid), 32'd1);
    step();
    abort = 1'b0;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_s_tready", 32'(s_tready), 32'd0);
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", 32'(done), 32'd0);
    end
    check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
    run_expect(2, 0, 1, 1'b0);

    // Reset mid-gap together with start.
    push_beats(4, 4);
    issue_start(4, 3, 3);
    repeat (5) @(negedge clock);
    step();
    reset = 1'b1;
    start = 1'b1;
    burst_length = 16'd2;
    burst_count  = 16'd1;
    @(negedge clock);
    step();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_s_tready", 32'(s_tready), 32'd0);
    check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_m_tlast", 32'(m_tlast), 32'd0);
    @(negedge clock);
    check("mid_rst_start_ignored", 32'(busy), 32'd0);
    check("mid_rst_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
